hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller_pkg.sv | 16 +
 rtl/hazard_controller_match.sv | 13 +
 rtl/hazard_controller.sv | 87 ++++++++
 tb/tb_hazard_controller.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/hazard_controller_pkg.sv
// hazard_controller_pkg: shared pipeline types, FSM encoding and sizing for the hazard controller
package hazard_controller_pkg;
  localparam int REG_W = 4;
  localparam int WAIT_W = 8;
  localparam int STALL_W = 16;
  localparam logic [WAIT_W-1:0] TIMEOUT_LIMIT = 8'd255;
  typedef enum logic {IDLE, MEM_WAIT} state_t;
  typedef struct packed {
    logic valid;
    logic wb_en;
    logic mem_r;
    logic mem_w;
    logic [REG_W-1:0] dest;
  } slot_t;
  localparam slot_t BUBBLE = '0;
endpackage

// File: rtl/hazard_controller_match.sv
// hazard_match: flags a source operand that is written by a live EXE or MEM shadow slot
module hazard_match
  import hazard_controller_pkg::*;
(
  input  logic [REG_W-1:0] i_src,
  input  logic [REG_W-1:0] i_exe_dest,
  input  logic             i_exe_live,
  input  logic [REG_W-1:0] i_mem_dest,
  input  logic             i_mem_live,
  output logic             o_match
);
  assign o_match = (i_exe_live & (i_exe_dest == i_src)) | (i_mem_live & (i_mem_dest == i_src));
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: RAW/load-use stall, branch flush and memory-wait freeze with timeout and stall counter
module hazard_controller
  import hazard_controller_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [REG_W-1:0]   src1,
  input  logic [REG_W-1:0]   src2,
  input  logic               Two_src,
  input  logic               id_wb_en,
  input  logic               id_mem_r_en,
  input  logic               id_mem_w_en,
  input  logic [REG_W-1:0]   id_dest,
  input  logic               exe_b_taken,
  input  logic               mem_ready,
  input  logic               fwd_en,
  output logic               hazard,
  output logic               flush,
  output logic               freeze,
  output logic               mem_timeout,
  output logic [STALL_W-1:0] stall_count
);
  state_t              r_state;
  slot_t               r_exe;
  slot_t               r_mem;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_mem_timeout;
  logic [STALL_W-1:0]  r_stall_count;
  logic                w_exe_live;
  logic                w_mem_live;
  logic                w_m1;
  logic                w_m2;
  logic                w_raw;
  logic                w_mem_busy;
  logic                w_timeout;
  // with forwarding only a load in EXE cannot be bypassed in time
  assign w_exe_live = r_exe.valid & r_exe.wb_en & (!fwd_en | r_exe.mem_r);
  assign w_mem_live = r_mem.valid & r_mem.wb_en & !fwd_en;
  hazard_match u_match1 (
    .i_src(src1), .i_exe_dest(r_exe.dest), .i_exe_live(w_exe_live),
    .i_mem_dest(r_mem.dest), .i_mem_live(w_mem_live), .o_match(w_m1)
  );
  hazard_match u_match2 (
    .i_src(src2), .i_exe_dest(r_exe.dest), .i_exe_live(w_exe_live),
    .i_mem_dest(r_mem.dest), .i_mem_live(w_mem_live), .o_match(w_m2)
  );
  assign w_raw = id_valid & (w_m1 | (Two_src & w_m2));
  assign w_mem_busy = r_mem.valid & (r_mem.mem_r | r_mem.mem_w);
  assign freeze = !rst & ((r_state == MEM_WAIT) | ((r_state == IDLE) & w_mem_busy & !mem_ready));
  assign flush = !rst & exe_b_taken & !freeze;
  assign hazard = !rst & w_raw & !exe_b_taken & !freeze;
  assign w_timeout = (r_state == MEM_WAIT) & !mem_ready & (r_wait == TIMEOUT_LIMIT);
  assign mem_timeout = r_mem_timeout;
  assign stall_count = r_stall_count;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_exe <= BUBBLE;
      r_mem <= BUBBLE;
      r_wait <= '0;
      r_mem_timeout <= 1'b0;
      r_stall_count <= '0;
    end else begin
      if ((hazard | freeze) && r_stall_count != '1) r_stall_count <= r_stall_count + STALL_W'(1);
      if (!freeze) begin
        r_mem <= r_exe;
        r_exe <= (hazard | flush | !id_valid) ? BUBBLE : slot_t'({1'b1, id_wb_en, id_mem_r_en, id_mem_w_en, id_dest});
      end else if (w_timeout) begin
        r_mem <= BUBBLE;
      end
      if (r_state == IDLE) begin
        if (freeze) begin
          r_state <= MEM_WAIT;
          r_wait <= '0;
        end
      end else if (mem_ready) begin
        r_state <= IDLE;
      end else if (w_timeout) begin
        r_state <= IDLE;
        r_mem_timeout <= 1'b1;
      end else begin
        r_wait <= r_wait + WAIT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed vectors with a queued scoreboard checked by a per-cycle monitor
module tb_hazard_controller;
  logic clk = 1'b0;
  logic rst, id_valid, Two_src, id_wb_en, id_mem_r_en, id_mem_w_en, exe_b_taken, mem_ready, fwd_en;
  logic [3:0] src1, src2, id_dest;
  logic hazard, flush, freeze, mem_timeout;
  logic [15:0] stall_count;
  typedef struct {
    string name;
    logic hz, fl, fz, to;
    logic [15:0] sc;
  } exp_t;
  exp_t q[$];
  exp_t m;
  int checks = 0;
  int failures = 0;
  logic [15:0] exp_sc = 16'd0;
  always #5 clk = ~clk;
  hazard_controller dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2), .Two_src(Two_src),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en), .id_dest(id_dest),
    .exe_b_taken(exe_b_taken), .mem_ready(mem_ready), .fwd_en(fwd_en),
    .hazard(hazard), .flush(flush), .freeze(freeze), .mem_timeout(mem_timeout), .stall_count(stall_count)
  );
  task automatic cmp(input string n, input logic [15:0] act, input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", n, act, exp_v);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      m = q.pop_front();
      cmp({m.name, ".hazard"}, 16'(hazard), 16'(m.hz));
      cmp({m.name, ".flush"}, 16'(flush), 16'(m.fl));
      cmp({m.name, ".freeze"}, 16'(freeze), 16'(m.fz));
      cmp({m.name, ".mem_timeout"}, 16'(mem_timeout), 16'(m.to));
      cmp({m.name, ".stall_count"}, stall_count, m.sc);
    end
  end
  task automatic id_set(input logic v, input logic [3:0] s1, input logic [3:0] s2, input logic two,
                        input logic wb, input logic mr, input logic mw, input logic [3:0] d);
    id_valid = v; src1 = s1; src2 = s2; Two_src = two;
    id_wb_en = wb; id_mem_r_en = mr; id_mem_w_en = mw; id_dest = d;
  endtask
  task automatic step(input string n, input logic hz, input logic fl, input logic fz, input logic to, input bit chk);
    if (chk) q.push_back('{n, hz, fl, fz, to, exp_sc});
    if ((hz | fz) && exp_sc != 16'hFFFF) exp_sc++;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; exe_b_taken = 1'b1; mem_ready = 1'b1; fwd_en = 1'b0;
    id_set(1, 1, 2, 1, 1, 0, 0, 3);
    @(posedge clk);
    #1;
    step("rst_gate", 0, 0, 0, 0, 1);
    rst = 1'b0; exe_b_taken = 1'b0;
    id_set(1, 1, 2, 1, 1, 0, 0, 3); step("raw_add", 0, 0, 0, 0, 1);
    id_set(1, 3, 4, 1, 1, 0, 0, 6); step("raw_exe", 1, 0, 0, 0, 1);
    step("raw_mem", 1, 0, 0, 0, 1);
    step("raw_clear", 0, 0, 0, 0, 1);
    id_set(1, 0, 6, 0, 0, 0, 0, 7); step("two_src_off", 0, 0, 0, 0, 1);
    id_set(1, 0, 6, 1, 0, 0, 0, 7); step("src2_mem", 1, 0, 0, 0, 1);
    id_set(0, 0, 0, 0, 0, 0, 0, 0); step("idle", 0, 0, 0, 0, 1);
    step("idle2", 0, 0, 0, 0, 1);
    fwd_en = 1'b1;
    id_set(1, 1, 0, 0, 1, 1, 0, 5); step("ldr", 0, 0, 0, 0, 1);
    id_set(1, 5, 0, 0, 1, 0, 0, 8); step("load_use", 1, 0, 0, 0, 1);
    step("load_use_done", 0, 0, 0, 0, 1);
    id_set(1, 8, 0, 0, 1, 0, 0, 9); step("alu_fwd", 0, 0, 0, 0, 1);
    id_set(0, 0, 0, 0, 0, 0, 0, 0); step("gap", 0, 0, 0, 0, 0);
    step("gap", 0, 0, 0, 0, 0);
    fwd_en = 1'b0;
    id_set(1, 1, 0, 0, 1, 0, 0, 3); step("br_prod", 0, 0, 0, 0, 1);
    id_set(1, 3, 0, 0, 1, 1, 0, 4); exe_b_taken = 1'b1; step("br_flush", 0, 1, 0, 0, 1);
    exe_b_taken = 1'b0; fwd_en = 1'b1;
    id_set(1, 4, 0, 0, 1, 0, 0, 10); step("br_bubble", 0, 0, 0, 0, 1);
    id_set(0, 0, 0, 0, 0, 0, 0, 0); step("gap", 0, 0, 0, 0, 0);
    step("gap", 0, 0, 0, 0, 0);
    id_set(1, 1, 0, 0, 1, 1, 0, 5); step("wait_ldr", 0, 0, 0, 0, 1);
    id_set(1, 2, 0, 0, 1, 0, 0, 6); step("wait_alu", 0, 0, 0, 0, 1);
    mem_ready = 1'b0;
    id_set(1, 7, 0, 0, 1, 0, 0, 11); step("wait_f0", 0, 0, 1, 0, 1);
    exe_b_taken = 1'b1; step("wait_br", 0, 0, 1, 0, 1);
    exe_b_taken = 1'b0; step("wait_f2", 0, 0, 1, 0, 1);
    step("wait_f3", 0, 0, 1, 0, 1);
    mem_ready = 1'b1; step("wait_rdy", 0, 0, 1, 0, 1);
    step("wait_go", 0, 0, 0, 0, 1);
    fwd_en = 1'b0;
    id_set(1, 6, 0, 0, 1, 0, 0, 12); step("wait_held", 1, 0, 0, 0, 1);
    id_set(0, 0, 0, 0, 0, 0, 0, 0); step("gap", 0, 0, 0, 0, 0);
    step("gap", 0, 0, 0, 0, 0);
    fwd_en = 1'b1;
    id_set(1, 1, 0, 0, 1, 1, 0, 5); step("to_ldr", 0, 0, 0, 0, 1);
    id_set(0, 0, 0, 0, 0, 0, 0, 0); step("to_gap", 0, 0, 0, 0, 1);
    mem_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (i < 257) step("to_frz", 0, 0, 1, 0, i == 0 || i == 1 || i == 256);
      else step("to_done", 0, 0, 0, 1, i == 257 || i == 299);
    end
    mem_ready = 1'b1;
    id_set(1, 1, 0, 0, 1, 1, 0, 5); step("rw_ldr", 0, 0, 0, 1, 1);
    id_set(0, 0, 0, 0, 0, 0, 0, 0); step("rw_gap", 0, 0, 0, 1, 0);
    mem_ready = 1'b0;
    step("rw_f0", 0, 0, 1, 1, 1);
    step("rw_f1", 0, 0, 1, 1, 0);
    step("rw_f2", 0, 0, 1, 1, 0);
    rst = 1'b1; step("rw_rst", 0, 0, 0, 1, 1);
    exp_sc = 16'd0; rst = 1'b0;
    step("rw_after", 0, 0, 0, 0, 1);
    step("rw_after2", 0, 0, 0, 0, 1);
    mem_ready = 1'b1;
    id_set(1, 1, 0, 0, 1, 1, 0, 5); step("r255_ldr", 0, 0, 0, 0, 1);
    id_set(0, 0, 0, 0, 0, 0, 0, 0); step("r255_gap", 0, 0, 0, 0, 0);
    mem_ready = 1'b0;
    for (int i = 0; i < 257; i++) begin
      if (i == 256) mem_ready = 1'b1;
      step("r255_frz", 0, 0, 1, 0, i == 0 || i == 256);
    end
    step("r255_go", 0, 0, 0, 0, 1);
    step("r255_after", 0, 0, 0, 0, 1);
    rst = 1'b1; step("sat_rst", 0, 0, 0, 0, 0);
    exp_sc = 16'd0; rst = 1'b0;
    fwd_en = 1'b1; mem_ready = 1'b0;
    id_set(1, 2, 0, 0, 1, 1, 0, 1); step("sat_a", 0, 0, 0, 0, 1);
    step("sat_b", 0, 0, 0, 0, 1);
    for (int k = 0; k < 65538; k++) begin
      mem_ready = (k % 100 == 99);
      step("sat", 0, 0, 1, 0, k == 65534 || k == 65537);
    end
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
